// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: drives a 4-digit active-low seven-segment display on behalf of two requesters.
// Ownership changes only on frame boundaries. Define SEG_BLINK_EN to add per-requester blinking.
module seg_scan_arbiter #(
  parameter int SCAN_DIV     = 100000,
  parameter int HOLD_FRAMES  = 250
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 125
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [27:0] glyph0,
  input  logic [27:0] glyph1,
`ifdef SEG_BLINK_EN
  input  logic [1:0]  blink,
`endif
  output logic [1:0]  grant,
  output logic        frame_tick,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        digit_q, digit_d;
  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        grant_q, grant_d;
  logic              frame_tick_q;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              slotTick, frameEnd, blankSlot;
  logic [27:0]       ownerGlyph;

  assign slotTick = (div_q == DIV_W'(SCAN_DIV - 1));
  assign frameEnd = slotTick && (digit_q == 2'd3);
  assign div_d    = slotTick ? '0 : div_q + DIV_W'(1);
  assign digit_d  = slotTick ? digit_q + 2'd1 : digit_q;

  // Requester 0 can only take the display from requester 1 once the hold window has elapsed.
  always_comb begin
    state_d = state_q;
    if (frameEnd) begin
      case (state_q)
        IDLE: begin
          if (req[0])      state_d = OWN0;
          else if (req[1]) state_d = OWN1;
        end
        OWN0: begin
          if (!req[0]) state_d = req[1] ? OWN1 : IDLE;
        end
        OWN1: begin
          if (!req[1])                                         state_d = req[0] ? OWN0 : IDLE;
          else if (req[0] && (hold_q >= HOLD_W'(HOLD_FRAMES))) state_d = OWN0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (frameEnd) begin
      if (state_d != state_q)
        hold_d = '0;
      else if ((state_q != IDLE) && (hold_q < HOLD_W'(HOLD_FRAMES)))
        hold_d = hold_q + HOLD_W'(1);
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
  logic               blinkPhase_q, blinkPhase_d;

  always_comb begin
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    if (frameEnd) begin
      if (blinkCnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else begin
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  // Next-state phase and owner are used so a whole frame blanks or shows uniformly.
  assign blankSlot = blinkPhase_d &&
                     (((state_d == OWN0) && blink[0]) || ((state_d == OWN1) && blink[1]));
`else
  assign blankSlot = 1'b0;
`endif

  always_comb begin
    ownerGlyph = (state_d == OWN1) ? glyph1 : glyph0;
    an_d       = an_q;
    seg_d      = seg_q;
    if (slotTick) begin
      if ((state_d == IDLE) || blankSlot) begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
      end else begin
        case (digit_d)
          2'd0: begin an_d = 4'b0111; seg_d = ownerGlyph[27:21]; end
          2'd1: begin an_d = 4'b1011; seg_d = ownerGlyph[20:14]; end
          2'd2: begin an_d = 4'b1101; seg_d = ownerGlyph[13:7];  end
          2'd3: begin an_d = 4'b1110; seg_d = ownerGlyph[6:0];   end
        endcase
      end
    end
  end

  assign grant_d = {state_d == OWN1, state_d == OWN0};

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q        <= '0;
      digit_q      <= 2'd0;
      state_q      <= IDLE;
      hold_q       <= '0;
      grant_q      <= 2'b00;
      frame_tick_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'h7F;
    end else begin
      div_q        <= div_d;
      digit_q      <= digit_d;
      state_q      <= state_d;
      hold_q       <= hold_d;
      grant_q      <= grant_d;
      frame_tick_q <= frameEnd;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign grant      = grant_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Testbench for seg_scan_arbiter: cycle-count reference model of scan, arbitration and display.
module tb_seg_scan_arbiter;

  localparam int SCAN_DIV    = 4;
  localparam int HOLD_FRAMES = 2;
  localparam int FRAME       = 4 * SCAN_DIV;
`ifdef SEG_BLINK_EN
  localparam int BLINK_FRAMES = 1;
  logic [1:0] blink;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [27:0] glyph0, glyph1;
  logic [1:0]  grant;
  logic        frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  // Reference model: edges counted since reset; owner 0=IDLE, 1=requester 0, 2=requester 1.
  int         edges;
  int         owner;
  int         held;
  logic [3:0] mAn;
  logic [6:0] mSeg;
  logic [1:0] mGrant;
  logic       mTick;

  seg_scan_arbiter #(
    .SCAN_DIV(SCAN_DIV),
    .HOLD_FRAMES(HOLD_FRAMES)
`ifdef SEG_BLINK_EN
    ,
    .BLINK_FRAMES(BLINK_FRAMES)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .req(req),
    .glyph0(glyph0),
    .glyph1(glyph1),
`ifdef SEG_BLINK_EN
    .blink(blink),
`endif
    .grant(grant),
    .frame_tick(frame_tick),
    .an(an),
    .seg(seg)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] fieldOf(input logic [27:0] g, input int d);
    return g[(3 - d) * 7 +: 7];
  endfunction

  task automatic arbitrate();
    int nxt;
    nxt = owner;
    case (owner)
      0: if (req[0]) nxt = 1; else if (req[1]) nxt = 2;
      1: if (!req[0]) nxt = req[1] ? 2 : 0;
      2: begin
        if (!req[1]) nxt = req[0] ? 1 : 0;
        else if (req[0] && held >= HOLD_FRAMES) nxt = 1;
      end
      default: nxt = 0;
    endcase
    if (nxt != owner) held = 0;
    else if (owner != 0) held = (held + 1 > HOLD_FRAMES) ? HOLD_FRAMES : held + 1;
    owner = nxt;
  endtask

  // One clock edge: update the model from the inputs seen at the edge, then settle past it.
  task automatic advance();
    int  d;
    bit  blank;
    @(posedge clock);
    if (reset) begin
      edges = 0; owner = 0; held = 0;
      mAn = 4'hF; mSeg = 7'h7F; mTick = 1'b0;
    end else begin
      edges++;
      mTick = (edges % FRAME == 0);
      if (mTick) arbitrate();
      if (edges % SCAN_DIV == 0) begin
        d = (edges / SCAN_DIV) % 4;
        blank = (owner == 0);
`ifdef SEG_BLINK_EN
        if (owner != 0 && (((edges / FRAME) / BLINK_FRAMES) % 2 == 1) &&
            ((owner == 1) ? blink[0] : blink[1]))
          blank = 1'b1;
`endif
        if (blank) begin
          mAn = 4'hF; mSeg = 7'h7F;
        end else begin
          mAn  = ~(4'b1000 >> d);
          mSeg = fieldOf((owner == 1) ? glyph0 : glyph1, d);
        end
      end
    end
    mGrant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    #1;
  endtask

  task automatic runUntil(input int phase);
    for (int i = 0; i < FRAME; i++) begin
      if (edges % FRAME == phase) break;
      advance();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00;
    advance();
    checks++;
    if ({an, seg, grant, frame_tick} !== {4'hF, 7'h7F, 2'b00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state got %b want %b", {an, seg, grant, frame_tick}, {4'hF, 7'h7F, 2'b00, 1'b0});
    end
    advance();
    reset = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL idle_frames edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
  endtask

  task automatic test_own0();
    runUntil(6);
    req = 2'b01; glyph0 = 28'h2410E06;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL own0_scan edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("[TB] FAIL own0_grant got %b want 01", grant);
    end
  endtask

  task automatic test_both_from_idle();
    req = 2'b00;
    runUntil(1);
    runUntil(5);
    req = 2'b11; glyph1 = 28'h0F0F0F0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL both_idle edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("[TB] FAIL both_idle_grant got %b want 01", grant);
    end
  endtask

  task automatic test_handoff();
    runUntil(3);
    req = 2'b10;
    for (int i = 0; i < 2 * FRAME; i++) begin
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL handoff edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
    checks++;
    if (grant !== 2'b10) begin
      errors++;
      $display("[TB] FAIL handoff_grant got %b want 10", grant);
    end
  endtask

  task automatic test_hold_preempt();
    req = 2'b00;
    runUntil(1);
    runUntil(4);
    req = 2'b10;
    runUntil(1);
    runUntil(2);
    req = 2'b11;
    for (int i = 0; i < 4 * FRAME; i++) begin
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL hold_preempt edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
  endtask

  task automatic test_own0_no_preempt();
    req = 2'b11;
    for (int i = 0; i < 10 * FRAME; i++) begin
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL own0_hold edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
    checks++;
    if (grant !== 2'b01) begin
      errors++;
      $display("[TB] FAIL own0_hold_grant got %b want 01", grant);
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b10;
    for (int i = 0; i < 3 * FRAME && owner != 2; i++) advance();
    runUntil(6);
    reset = 1'b1;
    advance();
    checks++;
    if ({an, seg, grant, frame_tick} !== {4'hF, 7'h7F, 2'b00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid got %b want %b", {an, seg, grant, frame_tick}, {4'hF, 7'h7F, 2'b00, 1'b0});
    end
    reset = 1'b0; req = 2'b01;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL rerequest edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 19) == 0) req = 2'($urandom_range(0, 3));
      glyph0 = 28'($urandom);
      glyph1 = 28'($urandom);
      reset  = ($urandom_range(0, 399) == 0);
      advance();
      checks++;
      if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
        errors++;
        $display("[TB] FAIL random edge %0d got %b want %b", edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
      end
    end
    reset = 1'b0;
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    reset = 1'b1; req = 2'b01; glyph0 = 28'h2410E06;
    advance();
    reset = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      blink = (pass == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < 4 * FRAME; i++) begin
        advance();
        checks++;
        if ({an, seg, grant, frame_tick} !== {mAn, mSeg, mGrant, mTick}) begin
          errors++;
          $display("[TB] FAIL blink%0d edge %0d got %b want %b", pass, edges, {an, seg, grant, frame_tick}, {mAn, mSeg, mGrant, mTick});
        end
      end
    end
    blink = 2'b00;
  endtask
`endif

  initial begin
    reset = 1'b1; req = 2'b00; glyph0 = '0; glyph1 = '0;
    edges = 0; owner = 0; held = 0;
    mAn = 4'hF; mSeg = 7'h7F; mGrant = 2'b00; mTick = 1'b0;
`ifdef SEG_BLINK_EN
    blink = 2'b00;
`endif
    test_reset();
    test_own0();
    test_both_from_idle();
    test_handoff();
    test_hold_preempt();
    test_own0_no_preempt();
    test_reset_mid();
    test_random();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
